// File: rtl/cpstr_mgr_rx.sv
// Demultiplexes one escaped control-plane byte stream into NUM_STREAMS output streams.
// Latency: one cycle from input accept to output valid; ESC/index bytes bypass output backpressure.
module cpstr_mgr_rx #(
   parameter int          NUM_STREAMS = 2,
   parameter logic [7:0]  ESC_CHAR    = 8'hA5,
   localparam int         IDX_W       = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [7:0]               i_data,
   input  logic                     i_valid,
   output logic                     o_ready,
   output logic [8*NUM_STREAMS-1:0] o_data,
   output logic [NUM_STREAMS-1:0]   o_valid,
   input  logic [NUM_STREAMS-1:0]   i_ready,
   output logic [IDX_W-1:0]         o_sel_idx,
   output logic                     o_err
);

   typedef enum logic {ST_DATA, ST_ESC} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic             discard_q, discard_d;
   logic             out_full_q, out_full_d;
   logic [7:0]       out_byte_q, out_byte_d;
   logic [IDX_W-1:0] out_dst_q, out_dst_d;
   logic             err_q, err_d;

   logic is_esc;
   logic idx_ok;
   logic is_data;
   logic drain;
   logic room;
   logic accept;

   assign is_esc  = (i_data == ESC_CHAR);
   assign idx_ok  = (32'(i_data) < 32'(NUM_STREAMS));
   assign is_data = (state_q == ST_DATA) ? !is_esc : is_esc;
   assign drain   = out_full_q && i_ready[out_dst_q];
   assign room    = !out_full_q || |(o_valid & i_ready);

   // Only bytes that would land in the output register can be stalled.
   assign o_ready = !is_data || discard_q || room;
   assign accept  = i_valid && o_ready;

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      discard_d  = discard_q;
      out_full_d = out_full_q && !drain;
      out_byte_d = out_byte_q;
      out_dst_d  = out_dst_q;
      err_d      = 1'b0;
      if (accept) begin
         if (state_q == ST_DATA && is_esc) begin
            state_d = ST_ESC;
         end else begin
            state_d = ST_DATA;
            if (is_data) begin
               if (!discard_q) begin
                  out_full_d = 1'b1;
                  out_byte_d = i_data;
                  out_dst_d  = sel_q;
               end
            end else if (idx_ok) begin
               sel_d     = i_data[IDX_W-1:0];
               discard_d = 1'b0;
            end else begin
               discard_d = 1'b1;
               err_d     = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_DATA;
         sel_q      <= '0;
         discard_q  <= 1'b1;
         out_full_q <= 1'b0;
         out_byte_q <= 8'h00;
         out_dst_q  <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         discard_q  <= discard_d;
         out_full_q <= out_full_d;
         out_byte_q <= out_byte_d;
         out_dst_q  <= out_dst_d;
         err_q      <= err_d;
      end
   end

   for (genvar k = 0; k < NUM_STREAMS; k++) begin : g_vld
      assign o_valid[k] = out_full_q && (out_dst_q == IDX_W'(k));
   end

   assign o_data    = {NUM_STREAMS{out_byte_q}};
   assign o_sel_idx = sel_q;
   assign o_err     = err_q;

endmodule

// File: tb/tb_cpstr_mgr_rx.sv
// Self-checking bench for cpstr_mgr_rx: table-driven byte sequences plus hand-written
// backpressure, index-switch and reset corner cases, with a scoreboard on the outputs.
module tb_cpstr_mgr_rx;

   logic        i_clk;
   logic        i_rst_n;
   logic [7:0]  i_data;
   logic        i_valid;
   logic        o_ready;
   logic [15:0] o_data;
   logic [1:0]  o_valid;
   logic [1:0]  i_ready;
   logic [0:0]  o_sel_idx;
   logic        o_err;

   cpstr_mgr_rx #(.NUM_STREAMS(2), .ESC_CHAR(8'hA5)) dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_sel_idx (o_sel_idx),
      .o_err     (o_err)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [7:0] dat;
      bit         out;
      int         dst;
      bit         err;
   } vec_t;

   typedef struct {
      logic [7:0] dat;
      int         dst;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Present one byte, wait (bounded) for acceptance, push any expected output.
   task automatic send(input logic [7:0] d, input bit out, input int dst, input bit err);
      bit done = 1'b0;
      i_data  = d;
      i_valid = 1'b1;
      for (int c = 0; c < 50 && !done; c++) begin
         @(negedge i_clk);
         if (o_ready) begin
            done = 1'b1;
            if (out) sb_q.push_back('{d, dst});
         end
         @(posedge i_clk);
         #1;
      end
      i_valid = 1'b0;
      if (!done) begin
         n_checks++;
         $display("FAIL send_timeout: byte %0h never accepted, expected acceptance", d);
      end else begin
         check($sformatf("err_after_%0h", d), 32'(o_err), 32'(err));
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 30 && sb_q.size() > 0; c++) @(posedge i_clk);
      repeat (2) @(posedge i_clk);
      #1;
      check("sb_empty", 32'(sb_q.size()), 32'd0);
   endtask

   always @(negedge i_clk) begin
      if (i_rst_n && |(o_valid & i_ready)) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_out: valid %b data %h, expected no output", o_valid, o_data);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("out_vld", 32'(o_valid), 32'(2'b01 << e.dst));
            check("out_dat", 32'((o_data >> (8 * e.dst)) & 16'h00FF), 32'(e.dat));
         end
      end
   end

   initial begin
      i_rst_n = 1'b0;
      i_valid = 1'b0;
      i_data  = 8'h00;
      i_ready = 2'b11;

      // dat, out, dst, err
      tbl.push_back('{8'h11, 1'b0, 0, 1'b0});
      tbl.push_back('{8'hA5, 1'b0, 0, 1'b0});
      tbl.push_back('{8'h01, 1'b0, 0, 1'b0});
      tbl.push_back('{8'h22, 1'b1, 1, 1'b0});
      tbl.push_back('{8'h33, 1'b1, 1, 1'b0});
      tbl.push_back('{8'hA5, 1'b0, 0, 1'b0});
      tbl.push_back('{8'h00, 1'b0, 0, 1'b0});
      tbl.push_back('{8'hA5, 1'b0, 0, 1'b0});
      tbl.push_back('{8'hA5, 1'b1, 0, 1'b0});
      tbl.push_back('{8'h44, 1'b1, 0, 1'b0});
      tbl.push_back('{8'hA5, 1'b0, 0, 1'b0});
      tbl.push_back('{8'h00, 1'b0, 0, 1'b0});
      tbl.push_back('{8'h55, 1'b1, 0, 1'b0});
      tbl.push_back('{8'hA5, 1'b0, 0, 1'b0});
      tbl.push_back('{8'h07, 1'b0, 0, 1'b1});
      tbl.push_back('{8'h66, 1'b0, 0, 1'b0});
      tbl.push_back('{8'hA5, 1'b0, 0, 1'b0});
      tbl.push_back('{8'h01, 1'b0, 0, 1'b0});
      tbl.push_back('{8'h77, 1'b1, 1, 1'b0});

      repeat (2) @(posedge i_clk);
      #1;
      check("rst_vld", 32'(o_valid), 32'd0);
      check("rst_err", 32'(o_err), 32'd0);
      check("rst_dat", 32'(o_data), 32'd0);
      check("rst_sel", 32'(o_sel_idx), 32'd0);
      i_rst_n = 1'b1;

      foreach (tbl[i]) begin
         send(tbl[i].dat, tbl[i].out, tbl[i].dst, tbl[i].err);
         if (i == 4) check("sel_after_seq1", 32'(o_sel_idx), 32'd1);
      end
      drain();
      check("sel_after_table", 32'(o_sel_idx), 32'd1);

      // Backpressure on stream 0.
      i_ready = 2'b10;
      send(8'hA5, 1'b0, 0, 1'b0);
      send(8'h00, 1'b0, 0, 1'b0);
      send(8'h01, 1'b1, 0, 1'b0);
      i_data  = 8'h02;
      i_valid = 1'b1;
      @(negedge i_clk);
      check("bp_rdy", 32'(o_ready), 32'd0);
      check("bp_hold_vld", 32'(o_valid), 32'd1);
      check("bp_hold_dat", 32'(o_data[7:0]), 32'h01);
      @(posedge i_clk);
      #1;
      i_ready = 2'b11;
      send(8'h02, 1'b1, 0, 1'b0);
      send(8'hA5, 1'b0, 0, 1'b0);
      send(8'h01, 1'b0, 0, 1'b0);
      drain();
      check("bp_sel", 32'(o_sel_idx), 32'd1);

      // Index switch while the register holds a stream-0 byte.
      i_ready = 2'b10;
      send(8'hA5, 1'b0, 0, 1'b0);
      send(8'h00, 1'b0, 0, 1'b0);
      send(8'h88, 1'b1, 0, 1'b0);
      send(8'hA5, 1'b0, 0, 1'b0);
      send(8'h01, 1'b0, 0, 1'b0);
      i_data  = 8'h99;
      i_valid = 1'b1;
      @(negedge i_clk);
      check("sw_rdy", 32'(o_ready), 32'd0);
      check("sw_hold_vld", 32'(o_valid), 32'd1);
      check("sw_hold_dat", 32'(o_data[7:0]), 32'h88);
      check("sw_sel", 32'(o_sel_idx), 32'd1);
      @(posedge i_clk);
      #1;
      i_ready = 2'b11;
      send(8'h99, 1'b1, 1, 1'b0);
      drain();

      // Reset while in ST_ESC with a held byte; that byte is lost.
      i_ready = 2'b10;
      send(8'hA5, 1'b0, 0, 1'b0);
      send(8'h00, 1'b0, 0, 1'b0);
      send(8'h12, 1'b0, 0, 1'b0);
      send(8'hA5, 1'b0, 0, 1'b0);
      check("pre_rst_vld", 32'(o_valid), 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("async_rst_vld", 32'(o_valid), 32'd0);
      check("async_rst_sel", 32'(o_sel_idx), 32'd0);
      check("async_rst_dat", 32'(o_data), 32'd0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      i_ready = 2'b11;
      send(8'h10, 1'b0, 0, 1'b0);
      send(8'hA5, 1'b0, 0, 1'b0);
      send(8'h01, 1'b0, 0, 1'b0);
      send(8'h20, 1'b1, 1, 1'b0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
